// File: rtl/y86_mem_arbiter.sv
// Shares the single-port Y86 data memory between fetch (read-only) and the memory stage.
// One access in flight; out-of-range addresses are answered with err and never reach memory.
module y86_mem_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DEPTH     = 1024,
  parameter int MEM_LAT   = 2,
  parameter int DATA_PRIO = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     f_req,
  input  logic [ADDR_W-1:0]        f_addr,
  output logic                     f_gnt,
  output logic                     f_rvalid,
  output logic [63:0]              f_rdata,
  output logic                     f_err,
  input  logic                     d_req,
  input  logic                     d_we,
  input  logic [ADDR_W-1:0]        d_addr,
  input  logic [63:0]              d_wdata,
  output logic                     d_gnt,
  output logic                     d_rvalid,
  output logic [63:0]              d_rdata,
  output logic                     d_err,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [63:0]              mem_wdata,
  input  logic [63:0]              mem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MEM_LAT + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic              own_d, last_d, we_q, oor_q;
  logic [AW-1:0]     addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       f_rdata_q, d_rdata_q;
  logic              f_err_q, d_err_q;
  logic              pick_d;
  logic [ADDR_W-1:0] sel_addr;

  // last_d=0 after reset means fetch counts as last granted, so data wins the first tie
  always_comb begin
    pick_d = d_req;
    if (f_req && d_req) pick_d = (DATA_PRIO != 0) || !last_d;
    sel_addr = pick_d ? d_addr : f_addr;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      own_d     <= 1'b0;
      last_d    <= 1'b0;
      we_q      <= 1'b0;
      oor_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      f_rdata_q <= '0;
      d_rdata_q <= '0;
      f_err_q   <= 1'b0;
      d_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (f_req || d_req) begin
          state   <= ISSUE;
          own_d   <= pick_d;
          last_d  <= pick_d;
          we_q    <= pick_d & d_we;
          addr_q  <= sel_addr[AW-1:0];
          wdata_q <= pick_d ? d_wdata : 64'd0;
          oor_q   <= sel_addr >= ADDR_W'(DEPTH);
        end
        ISSUE: begin
          if (oor_q) begin
            state <= RESP;
            if (own_d) begin d_rdata_q <= '0; d_err_q <= 1'b1; end
            else       begin f_rdata_q <= '0; f_err_q <= 1'b1; end
          end else if (we_q) begin
            state <= IDLE;
          end else begin
            state <= WAIT;
            cnt   <= CW'(MEM_LAT);
          end
        end
        WAIT: begin
          if (cnt == CW'(1)) begin
            state <= RESP;
            if (own_d) begin d_rdata_q <= mem_rdata; d_err_q <= 1'b0; end
            else       begin f_rdata_q <= mem_rdata; f_err_q <= 1'b0; end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign f_gnt     = (state == ISSUE) && !own_d;
  assign d_gnt     = (state == ISSUE) &&  own_d;
  assign mem_en    = (state == ISSUE) && !oor_q;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign f_rvalid  = (state == RESP) && !own_d;
  assign d_rvalid  = (state == RESP) &&  own_d;
  assign f_rdata   = f_rdata_q;
  assign f_err     = f_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
endmodule
